// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared types and constants for the round-robin FIFO read scheduler.
//   sched_state_e : scheduler FSM states
//   DATA_W_DEF    : default FIFO word width
//   TH_W_DEF      : default almost-empty/almost-full threshold width
//   CNT_W/CNT_MAX : width and saturation value of the optional grant counters
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ARB   = 2'd2,
    PAUSE = 2'd3
  } sched_state_e;

  localparam int          DATA_W_DEF = 6;
  localparam int          TH_W_DEF   = 5;
  localparam int          CNT_W      = 16;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first eligible requester at or
// after i_ptr, wrapping modulo N_REQ.
//   i_eligible  : per-requester eligibility
//   i_ptr       : search start index
//   o_grant     : one-hot grant (zero when nothing is eligible)
//   o_idx       : index of the granted requester
//   o_any_grant : high when some requester is eligible
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_eligible,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any_grant
);

  // Scan N_REQ positions starting at the pointer; first hit wins.
  always_comb begin
    logic [PTR_W-1:0] w_j;
    logic             w_hit;
    logic             w_found;
    o_grant     = '0;
    o_idx       = '0;
    w_found     = 1'b0;
    w_j         = '0;
    w_hit       = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      // N_REQ is a power of two, so the add wraps naturally.
      w_j   = i_ptr + PTR_W'(k);
      w_hit = ~w_found & i_eligible[w_j];
      if (w_hit) begin
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        w_found      = 1'b1;
      end else begin
        w_found      = w_found;
      end
    end
    o_any_grant = w_found;
  end

endmodule

// File: rtl/fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// fifo_rr_sched
// Read-side scheduler that shares one DATA_W output path among N_REQ upstream
// FIFOs. Pops are issued one-hot in round-robin order; the popped word is
// delivered on data_out/valid_out two cycles after its fifo_rd strobe.
// Threshold configuration is latched once after reset and broadcast.
//
// Ports:
//   clk          : clock, all logic on posedge
//   RESET        : synchronous active-high reset
//   fifo_empty   : empty flag per FIFO
//   fifo_data    : data_out per FIFO, requester i at [i*DATA_W +: DATA_W]
//   pause        : downstream almost-full, blocks new pops
//   cfg_al_empty : almost-empty threshold, sampled in INIT
//   cfg_al_full  : almost-full threshold, sampled in INIT
//   fifo_rd      : registered one-hot pop strobe
//   al_empty_out : latched almost-empty threshold
//   al_full_out  : latched almost-full threshold
//   data_out     : registered scheduled word
//   valid_out    : data_out qualifier
//   sched_idle   : no pop pending or in flight
//   grant_cnt    : per-requester 16-bit saturating grant counters
//                  (present only when SCHED_STATS_EN is defined)
// -----------------------------------------------------------------------------
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_REQ  = 4,
  parameter int TH_W   = TH_W_DEF
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        fifo_empty,
  input  logic [N_REQ*DATA_W-1:0] fifo_data,
  input  logic                    pause,
  input  logic [TH_W-1:0]         cfg_al_empty,
  input  logic [TH_W-1:0]         cfg_al_full,
  output logic [N_REQ-1:0]        fifo_rd,
  output logic [TH_W-1:0]         al_empty_out,
  output logic [TH_W-1:0]         al_full_out,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic                    sched_idle
`ifdef SCHED_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [N_REQ-1:0]  r_fifo_rd;
  logic [PTR_W-1:0]  r_rd_idx;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_sel_q;
  logic              r_vld_q;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [TH_W-1:0]   r_al_empty;
  logic [TH_W-1:0]   r_al_full;

  logic [N_REQ-1:0]  w_eligible;
  logic [N_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic [N_REQ-1:0]  w_fifo_rd_nxt;
  logic              w_take;
  logic              w_ld_cfg;
  logic [DATA_W-1:0] w_word;

  // A requester popped last cycle is skipped: its empty flag lags by one cycle.
  assign w_eligible = ~fifo_empty & ~r_fifo_rd;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_eligible  (w_eligible),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_idx       (w_idx),
    .o_any_grant (w_any)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; PAUSE re-arbitrates on the same edge pause drops.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT: w_state_nxt = IDLE;
      IDLE, ARB, PAUSE: begin
        if (!pause && w_any) begin
          w_state_nxt = ARB;
        end else if (pause) begin
          w_state_nxt = PAUSE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  // FSM output decode: pop strobe and config load.
  always_comb begin
    w_take        = 1'b0;
    w_ld_cfg      = 1'b0;
    w_fifo_rd_nxt = '0;
    case (r_state)
      INIT: w_ld_cfg = 1'b1;
      IDLE, ARB, PAUSE: begin
        w_take        = ~pause & w_any;
        w_fifo_rd_nxt = w_take ? w_grant : '0;
      end
      default: w_ld_cfg = 1'b0;
    endcase
  end

  // Pop strobe, winner index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_fifo_rd <= '0;
      r_rd_idx  <= '0;
      r_ptr     <= '0;
    end else begin
      r_fifo_rd <= w_fifo_rd_nxt;
      if (w_take) begin
        r_rd_idx <= w_idx;
        r_ptr    <= w_idx + PTR_W'(1);
      end else begin
        r_rd_idx <= r_rd_idx;
        r_ptr    <= r_ptr;
      end
    end
  end

  assign w_word = fifo_data[r_sel_q*DATA_W +: DATA_W];

  // Two-stage delivery: grant index follows the strobe, then the word is
  // captured in the cycle the FIFO presents it.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_sel_q <= '0;
      r_vld_q <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sel_q <= r_rd_idx;
      r_vld_q <= |r_fifo_rd;
      r_valid <= r_vld_q;
      if (r_vld_q) begin
        r_data <= w_word;
      end else begin
        r_data <= r_data;
      end
    end
  end

  // Threshold latch, loaded once in INIT and held until the next reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_al_empty <= '0;
      r_al_full  <= '0;
    end else if (w_ld_cfg) begin
      r_al_empty <= cfg_al_empty;
      r_al_full  <= cfg_al_full;
    end else begin
      r_al_empty <= r_al_empty;
      r_al_full  <= r_al_full;
    end
  end

  assign fifo_rd      = r_fifo_rd;
  assign data_out     = r_data;
  assign valid_out    = r_valid;
  assign al_empty_out = r_al_empty;
  assign al_full_out  = r_al_full;
  assign sched_idle   = (r_state != ARB) & ~|r_fifo_rd & ~r_vld_q;

`ifdef SCHED_STATS_EN
  logic [CNT_W-1:0] r_cnt [N_REQ];

  // Per-requester grant counters, saturating at CNT_MAX.
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (r_fifo_rd[i] && (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_sched
// Directed bench for fifo_rr_sched. Four behavioural FIFOs feed the DUT; every
// pop pushes the popped word onto a scoreboard queue and every valid_out pops
// and compares it. Directed steps check strobes, thresholds and idle status.
// -----------------------------------------------------------------------------
module tb_fifo_rr_sched;

  localparam int DW = 6;
  localparam int NR = 4;
  localparam int TW = 5;

  logic            clk = 1'b0;
  logic            RESET;
  logic [NR-1:0]   fifo_empty;
  logic [NR*DW-1:0] fifo_data;
  logic            pause;
  logic [TW-1:0]   cfg_al_empty;
  logic [TW-1:0]   cfg_al_full;
  logic [NR-1:0]   fifo_rd;
  logic [TW-1:0]   al_empty_out;
  logic [TW-1:0]   al_full_out;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic            sched_idle;
`ifdef SCHED_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural FIFO storage: registered read data, one-cycle empty lag.
  logic [DW-1:0] mem [NR][16];
  logic [DW-1:0] fd  [NR];
  int            head [NR] = '{0, 0, 0, 0};
  int            tail [NR] = '{0, 0, 0, 0};
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_w;

  fifo_rr_sched dut (
    .clk          (clk),
    .RESET        (RESET),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .pause        (pause),
    .cfg_al_empty (cfg_al_empty),
    .cfg_al_full  (cfg_al_full),
    .fifo_rd      (fifo_rd),
    .al_empty_out (al_empty_out),
    .al_full_out  (al_full_out),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .sched_idle   (sched_idle)
`ifdef SCHED_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIFO flags and read data seen by the DUT.
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      fifo_empty[i]          = (head[i] == tail[i]);
      fifo_data[i*DW +: DW]  = fd[i];
    end
  end

  // FIFO pop model and scoreboard push; reset discards anything in flight.
  always @(posedge clk) begin
    if (RESET) exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      if (fifo_rd[i]) begin
        fd[i]   <= mem[i][head[i]];
        if (!RESET) exp_q.push_back(mem[i][head[i]]);
        head[i] <= head[i] + 1;
      end
    end
  end

  // Scoreboard check on every delivered word.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_extra: got %0h, want no word", data_out);
      end else begin
        exp_w = exp_q.pop_front();
        assert (data_out === exp_w) else begin
          n_fail++;
          $error("FAIL sb_data: got %0h, want %0h", data_out, exp_w);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int f, input logic [DW-1:0] w);
    mem[f][tail[f]] = w;
    tail[f] = tail[f] + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NR-1:0] rr_exp [6];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < NR; i++) fd[i] = '0;
    RESET        = 1'b1;
    pause        = 1'b0;
    cfg_al_empty = 5'd2;
    cfg_al_full  = 5'd6;

    // Reset held two cycles, then INIT latches thresholds.
    tick();
    tick();
    chk("rst_rd",    fifo_rd,      4'b0000);
    chk("rst_data",  data_out,     6'd0);
    chk("rst_valid", valid_out,    1'b0);
    chk("rst_ae",    al_empty_out, 5'd0);
    chk("rst_af",    al_full_out,  5'd0);
    chk("rst_idle",  sched_idle,   1'b1);
    RESET = 1'b0;
    tick();
    chk("init_ae",   al_empty_out, 5'd2);
    chk("init_af",   al_full_out,  5'd6);
    chk("init_idle", sched_idle,   1'b1);

    // Single requester: pop, no repeat, word two cycles later.
    push(0, 6'b010010);
    tick();
    chk("single_rd",      fifo_rd,    4'b0001);
    chk("single_busy",    sched_idle, 1'b0);
    tick();
    chk("single_norep",   fifo_rd,    4'b0000);
    tick();
    chk("single_valid",   valid_out,  1'b1);
    chk("single_data",    data_out,   6'b010010);
    chk("single_idle",    sched_idle, 1'b1);

    // Reset again (pointer back to 0) with new thresholds.
    cfg_al_empty = 5'd3;
    cfg_al_full  = 5'd7;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    chk("reinit_ae", al_empty_out, 5'd3);
    chk("reinit_af", al_full_out,  5'd7);
    cfg_al_empty = 5'd1;
    cfg_al_full  = 5'd1;

    // Round robin over four non-empty FIFOs.
    for (int f = 0; f < NR; f++) begin
      for (int k = 0; k < 3; k++) push(f, DW'(f * 8 + k + 1));
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_rd", fifo_rd, rr_exp[k]);
      if (k >= 2) chk("rr_valid", valid_out, 1'b1);
    end
    chk("hold_ae", al_empty_out, 5'd3);
    chk("hold_af", al_full_out,  5'd7);

    // Pause mid-burst: in-flight words still delivered.
    pause = 1'b1;
    tick();
    chk("pause_rd1", fifo_rd,   4'b0000);
    chk("pause_v1",  valid_out, 1'b1);
    tick();
    chk("pause_rd2", fifo_rd,   4'b0000);
    chk("pause_v2",  valid_out, 1'b1);
    tick();
    chk("pause_rd3", fifo_rd,   4'b0000);
    chk("pause_v3",  valid_out, 1'b0);
    pause = 1'b0;
    tick();
    chk("resume_rd", fifo_rd,   4'b0100);
    tick();
    chk("resume_rd2", fifo_rd,  4'b1000);
    repeat (7) tick();
    chk("drain_idle", sched_idle,   1'b1);
    chk("drain_sb",   exp_q.size(), 0);

    // Empty boundary: one word in FIFO2 only.
    push(2, 6'b101101);
    tick();
    chk("bnd_rd",    fifo_rd,    4'b0100);
    chk("bnd_busy",  sched_idle, 1'b0);
    tick();
    chk("bnd_rd2",   fifo_rd,    4'b0000);
    tick();
    chk("bnd_rd3",   fifo_rd,    4'b0000);
    chk("bnd_valid", valid_out,  1'b1);
    chk("bnd_idle",  sched_idle, 1'b1);
    tick();
    chk("bnd_rd4",   fifo_rd,    4'b0000);

    // Reset mid-operation discards in-flight words.
    push(0, 6'b000111);
    push(1, 6'b111000);
    tick();
    chk("mid_rd1", fifo_rd, 4'b0001);
    tick();
    chk("mid_rd2", fifo_rd, 4'b0010);
    RESET = 1'b1;
    tick();
    chk("mid_rst_rd",    fifo_rd,      4'b0000);
    chk("mid_rst_valid", valid_out,    1'b0);
    chk("mid_rst_data",  data_out,     6'd0);
    chk("mid_rst_ae",    al_empty_out, 5'd0);
    RESET = 1'b0;
    tick();
    chk("mid_init_valid", valid_out, 1'b0);
    tick();
    chk("mid_post_valid", valid_out, 1'b0);
    chk("mid_sb",         exp_q.size(), 0);

    // Five words to FIFO1 only: served every other cycle.
    for (int k = 0; k < 5; k++) push(1, DW'(40 + k));
    tick();
    chk("solo_rd1", fifo_rd, 4'b0010);
    tick();
    chk("solo_gap", fifo_rd, 4'b0000);
    tick();
    chk("solo_rd2", fifo_rd, 4'b0010);
    repeat (12) tick();
    chk("solo_idle", sched_idle,   1'b1);
    chk("solo_sb",   exp_q.size(), 0);
`ifdef SCHED_STATS_EN
    chk("stats_f1", grant_cnt[31:16], 16'd5);
    chk("stats_f0", grant_cnt[15:0],  16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
